// File: rtl/olink_tx_framer.sv
// Transmit framer for the 16-bit 8b/10b optical link: 32-bit words out as low/high halves,
// with periodic comma insertion, IDLE fill and PAD substitution. Status counters exist only
// when OLINK_TX_CNT_EN is defined.
module olink_tx_framer #(
  parameter int unsigned COMMA_PERIOD = 64,
  parameter logic [7:0]  COMMA_HI     = 8'h50
) (
  input  logic        clk_link,
  input  logic        reset,
  input  logic [31:0] in_d,
  input  logic [3:0]  in_k,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] tx_d,
  output logic [1:0]  tx_k,
  input  logic        cnt_reset,
  output logic [31:0] cnt_words,
  output logic [15:0] cnt_illegal,
  output logic [31:0] cnt_comma
);

  localparam logic [15:0] PeriodM1  = 16'(COMMA_PERIOD - 1);
  localparam logic [31:0] IdleWord  = 32'hF7F7_F7F7;
  localparam logic [31:0] PadWord   = 32'h1C1C_1C1C;
  localparam logic [31:0] CommaWord = {16'h0000, COMMA_HI, 8'hBC};

  logic        phase_q;
  logic [15:0] comma_cnt_q;
  logic [15:0] hold_q;
  logic [1:0]  hold_k_q;

  logic        comma_due;
  logic        pass_comma;
  logic        legal;
  logic        comma_sel;
  logic [31:0] sel_d;
  logic [3:0]  sel_k;

  always_comb begin
    comma_due  = (comma_cnt_q == PeriodM1);
    in_ready   = !phase_q && !comma_due && !reset;
    pass_comma = (in_k == 4'b0001) && (in_d[7:0] == 8'hBC);
    legal      = (in_k == 4'b0000) || (in_k == 4'b1111) || pass_comma;
    sel_d      = IdleWord;
    sel_k      = 4'b1111;
    comma_sel  = 1'b0;
    if (comma_due) begin
      sel_d     = CommaWord;
      sel_k     = 4'b0001;
      comma_sel = 1'b1;
    end else if (in_valid) begin
      if (legal) begin
        sel_d     = in_d;
        sel_k     = in_k;
        comma_sel = pass_comma;
      end else begin
        sel_d = PadWord;
        sel_k = 4'b1111;
      end
    end
  end

  always_ff @(posedge clk_link) begin
    if (reset) begin
      phase_q     <= 1'b0;
      tx_d        <= 16'hF7F7;
      tx_k        <= 2'b11;
      hold_q      <= 16'hF7F7;
      hold_k_q    <= 2'b11;
      comma_cnt_q <= PeriodM1;
    end else begin
      phase_q <= !phase_q;
      if (!phase_q) begin
        tx_d        <= sel_d[15:0];
        tx_k        <= sel_k[1:0];
        hold_q      <= sel_d[31:16];
        hold_k_q    <= sel_k[3:2];
        comma_cnt_q <= comma_sel ? 16'd0 : comma_cnt_q + 16'd1;
      end else begin
        tx_d <= hold_q;
        tx_k <= hold_k_q;
      end
    end
  end

`ifdef OLINK_TX_CNT_EN
  logic take;
  logic illegal_take;
  logic comma_sent;

  always_comb begin
    take         = in_valid && in_ready;
    illegal_take = take && !legal;
    comma_sent   = !phase_q && comma_sel;
  end

  // Clear has priority over any coincident increment.
  always_ff @(posedge clk_link) begin
    if (reset || cnt_reset) begin
      cnt_words   <= 32'd0;
      cnt_illegal <= 16'd0;
      cnt_comma   <= 32'd0;
    end else begin
      if (take) cnt_words <= cnt_words + 32'd1;
      if (illegal_take && cnt_illegal != 16'hFFFF) cnt_illegal <= cnt_illegal + 16'd1;
      if (comma_sent) cnt_comma <= cnt_comma + 32'd1;
    end
  end
`else
  logic unused_cnt_reset;

  assign unused_cnt_reset = cnt_reset;
  assign cnt_words        = 32'd0;
  assign cnt_illegal      = 16'd0;
  assign cnt_comma        = 32'd0;
`endif

endmodule

// File: tb/tb_olink_tx_framer.sv
// Bench for olink_tx_framer: directed scenarios plus random traffic against a slot-level model.
module tb_olink_tx_framer;

  localparam int P = 4;

  logic        clk_link = 1'b0;
  logic        reset;
  logic [31:0] in_d;
  logic [3:0]  in_k;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] tx_d;
  logic [1:0]  tx_k;
  logic        cnt_reset;
  logic [31:0] cnt_words;
  logic [15:0] cnt_illegal;
  logic [31:0] cnt_comma;

  always #5 clk_link = ~clk_link;

  olink_tx_framer #(
    .COMMA_PERIOD(P),
    .COMMA_HI    (8'h50)
  ) dut (
    .clk_link   (clk_link),
    .reset      (reset),
    .in_d       (in_d),
    .in_k       (in_k),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_d       (tx_d),
    .tx_k       (tx_k),
    .cnt_reset  (cnt_reset),
    .cnt_words  (cnt_words),
    .cnt_illegal(cnt_illegal),
    .cnt_comma  (cnt_comma)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: slot index, slot of last comma, queue of expected half-words.
  int          m_cyc;
  int          m_slot;
  int          m_last;
  logic [17:0] m_q[$];
  logic [15:0] e_tx;
  logic [1:0]  e_k;
  logic [31:0] m_words;
  logic [31:0] m_comma;
  logic [15:0] m_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    tests++;
    assert (obs === req)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef OLINK_TX_CNT_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k,
                      input logic r, input logic cr);
    logic        due;
    logic        rdy;
    logic [31:0] w;
    logic [3:0]  wk;
    logic [17:0] h;
    in_valid  = v;
    in_d      = d;
    in_k      = k;
    reset     = r;
    cnt_reset = cr;
    #1;
    due = (m_cyc % 2 == 0) && (m_slot - m_last >= P);
    rdy = !r && (m_cyc % 2 == 0) && !due;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    if (r) begin
      m_cyc   = 0;
      m_slot  = 0;
      m_last  = -P;
      m_q.delete();
      e_tx    = 16'hF7F7;
      e_k     = 2'b11;
      m_words = 0;
      m_comma = 0;
      m_ill   = 0;
    end else begin
      if (m_cyc % 2 == 0) begin
        if (due) begin
          w = 32'h0000_50BC; wk = 4'b0001;
          m_last = m_slot; m_comma++;
        end else if (v) begin
          m_words++;
          case (k)
            4'b0000, 4'b1111: begin w = d; wk = k; end
            4'b0001: begin
              if (d[7:0] == 8'hBC) begin
                w = d; wk = k; m_last = m_slot; m_comma++;
              end else begin
                w = 32'h1C1C_1C1C; wk = 4'hF;
                if (m_ill != 16'hFFFF) m_ill++;
              end
            end
            default: begin
              w = 32'h1C1C_1C1C; wk = 4'hF;
              if (m_ill != 16'hFFFF) m_ill++;
            end
          endcase
        end else begin
          w = 32'hF7F7_F7F7; wk = 4'hF;
        end
        m_slot++;
        m_q.push_back({wk[1:0], w[15:0]});
        m_q.push_back({wk[3:2], w[31:16]});
      end
      h    = m_q.pop_front();
      e_k  = h[17:16];
      e_tx = h[15:0];
      m_cyc++;
      if (cr) begin
        m_words = 0;
        m_comma = 0;
        m_ill   = 0;
      end
    end
    @(posedge clk_link);
    #1;
    chk("tx_d", {16'd0, tx_d}, {16'd0, e_tx});
    chk("tx_k", {30'd0, tx_k}, {30'd0, e_k});
    chk("cnt_words", cnt_words, cnt_exp(m_words));
    chk("cnt_illegal", {16'd0, cnt_illegal}, cnt_exp({16'd0, m_ill}));
    chk("cnt_comma", cnt_comma, cnt_exp(m_comma));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    in_valid = 1'b0; in_d = '0; in_k = '0; reset = 1'b1; cnt_reset = 1'b0;
    m_cyc = 0; m_slot = 0; m_last = -P; e_tx = 16'hF7F7; e_k = 2'b11;
    m_words = 0; m_comma = 0; m_ill = 0;

    do_reset(3);
    chk("reset_tx_d", {16'd0, tx_d}, 32'h0000_F7F7);
    chk("reset_ready", {31'd0, in_ready}, 32'd0);

    // Idle link: comma, then IDLE, comma again after P slots.
    idle(1);
    chk("first_comma", {14'd0, tx_k, tx_d}, 32'h0001_50BC);
    idle(9);
    chk("cnt_comma_5slots", cnt_comma, cnt_exp(32'd2));
    idle(10);

    // Continuous traffic.
    for (int i = 0; i < 24; i++) step(1'b1, 32'h4433_2211, 4'b0000, 1'b0, 1'b0);

    // Illegal K pattern becomes PAD.
    do_reset(1);
    idle(2);
    step(1'b1, 32'hAABB_CCDD, 4'b0010, 1'b0, 1'b0);
    chk("pad_lo", {14'd0, tx_k, tx_d}, 32'h0003_1C1C);
    idle(1);
    chk("pad_hi", {14'd0, tx_k, tx_d}, 32'h0003_1C1C);
    chk("pad_ill", {16'd0, cnt_illegal}, cnt_exp(32'd1));
    chk("pad_words", cnt_words, cnt_exp(32'd1));

    // Pass-through comma at counter=1.
    do_reset(1);
    idle(4);
    step(1'b1, 32'h1234_5FBC, 4'b0001, 1'b0, 1'b0);
    chk("pass_comma", {14'd0, tx_k, tx_d}, 32'h0001_5FBC);
    idle(2 * P + 4);

    // Reset during the high half of a data word.
    do_reset(1);
    idle(2);
    step(1'b1, 32'hDEAD_BEEF, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("midslot_reset", {14'd0, tx_k, tx_d}, 32'h0003_F7F7);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd0);
    idle(2);

    // cnt_reset coincident with a handshake.
    step(1'b1, 32'h0102_0304, 4'b0000, 1'b0, 1'b1);
    chk("cntrst_words", cnt_words, 32'd0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      logic [3:0]  k;
      int          sel;
      d   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 5) k = 4'b0000;
      else if (sel == 5) k = 4'b1111;
      else if (sel == 6) begin
        k = 4'b0001;
        if ($urandom_range(0, 1) == 1) d[7:0] = 8'hBC;
      end else k = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 3) != 0), d, k, ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
